// File: rtl/hamming_sched_pkg.sv
// Shared types and frame-geometry helpers for the hamming encoder scheduler.
// Geometry is a function of the check-bit count and the extended-code flag.
package hamming_sched_pkg;

    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    // Payload bits of a (2^r-1, 2^r-1-r) hamming code.
    function automatic int calc_k(input int r);
        return (1 << r) - 1 - r;
    endfunction

    // Frame length; the extended code appends one overall parity bit.
    function automatic int calc_n(input int r, input int ext);
        return (ext != 0) ? (1 << r) : (1 << r) - 1;
    endfunction

endpackage

// File: rtl/hamming_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above iptr, with wrap-around.
// Outputs a one-hot grant, its index and a found flag.
module hamming_rr_arb #(
    parameter int pN_REQ = 4,
    parameter int pIDX_W = $clog2(pN_REQ)
) (
    input  logic [pN_REQ-1:0] ireq,
    input  logic [pIDX_W-1:0] iptr,
    output logic [pN_REQ-1:0] ognt,
    output logic [pIDX_W-1:0] oidx,
    output logic              ofound
);

    logic [pIDX_W:0] sum;
    logic [pIDX_W-1:0] cand;

    always_comb begin
        oidx   = '0;
        ofound = 1'b0;
        sum    = '0;
        cand   = '0;
        // Walk offsets from far to near so the nearest hit is the last one written.
        for (int k = pN_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, iptr} + (pIDX_W + 1)'(k);
            if (sum >= (pIDX_W + 1)'(pN_REQ)) begin
                sum = sum - (pIDX_W + 1)'(pN_REQ);
            end
            cand = sum[pIDX_W-1:0];
            if (ireq[cand]) begin
                oidx   = cand;
                ofound = 1'b1;
            end
        end
        ognt = ofound ? (pN_REQ'(1) << oidx) : '0;
    end

endmodule

// File: rtl/hamming_enc_sched.sv
// Round-robin front end for a shared serial hamming encoder: grants one requester,
// serializes its word LSB-first and generates sop/val/eop/eof/tag framing.
module hamming_enc_sched
    import hamming_sched_pkg::*;
#(
    parameter int pR     = 6,
    parameter int pEXT   = 1,
    parameter int pN_REQ = 4,
    parameter int pTAG_W = 2,
    localparam int cK    = calc_k(pR),
    localparam int cN    = calc_n(pR, pEXT)
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic [pN_REQ-1:0]    ireq_val,
    input  logic [pN_REQ*cK-1:0] ireq_dat,
    output logic [pN_REQ-1:0]    oreq_rdy,
    output logic                 oenc_sop,
    output logic                 oenc_val,
    output logic                 oenc_eop,
    output logic                 oenc_eof,
    output logic [pTAG_W-1:0]    oenc_tag,
    output logic                 oenc_dat,
    output logic                 obusy
);

    localparam int cIW = $clog2(pN_REQ);
    localparam int cCW = $clog2(cN + 1);

    localparam logic [cCW-1:0] cCNT_LAST  = cCW'(cN - 1);
    localparam logic [cCW-1:0] cCNT_K     = cCW'(cK);
    localparam logic [cCW-1:0] cCNT_KLAST = cCW'(cK - 1);
    localparam logic [cIW-1:0] cPTR_LAST  = cIW'(pN_REQ - 1);

    state_t              state_q, state_d;
    logic [cCW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [cIW-1:0]      ptr_q, ptr_d;
    logic [cK-1:0]       sreg_q, sreg_d;
    logic [pN_REQ-1:0]   rdy_q, rdy_d;
    logic                sop_q, sop_d;
    logic                val_q, val_d;
    logic                eop_q, eop_d;
    logic                eof_q, eof_d;
    logic [pTAG_W-1:0]   tag_q, tag_d;
    logic                dat_q, dat_d;
    logic                busy_q, busy_d;

    logic [pN_REQ-1:0]   arb_gnt;
    logic [cIW-1:0]      arb_idx;
    logic                arb_found;
    logic [cK-1:0]       win_word;
    logic                frame_last;
    logic                arb_en;

    hamming_rr_arb #(
        .pN_REQ (pN_REQ),
        .pIDX_W (cIW)
    ) u_arb (
        .ireq   (ireq_val),
        .iptr   (ptr_q),
        .ognt   (arb_gnt),
        .oidx   (arb_idx),
        .ofound (arb_found)
    );

    always_comb begin
        win_word = '0;
        for (int i = 0; i < pN_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_word = ireq_dat[i*cK +: cK];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        sreg_d     = sreg_q;
        rdy_d      = '0;
        sop_d      = 1'b0;
        val_d      = 1'b0;
        eop_d      = 1'b0;
        eof_d      = 1'b0;
        tag_d      = tag_q;
        dat_d      = dat_q;
        cnt_inc    = cnt_q + 1'b1;
        frame_last = (state_q == CHECK) && (cnt_q == cCNT_LAST);
        arb_en     = (state_q == IDLE) || frame_last;

        if (arb_en && arb_found) begin
            // Grant: the registered outputs present frame cycle 0 on the next cycle.
            state_d = DATA;
            cnt_d   = '0;
            rdy_d   = arb_gnt;
            ptr_d   = (arb_idx == cPTR_LAST) ? '0 : arb_idx + 1'b1;
            tag_d   = pTAG_W'(arb_idx);
            sreg_d  = win_word >> 1;
            dat_d   = win_word[0];
            sop_d   = 1'b1;
            val_d   = 1'b1;
            eop_d   = (cCNT_KLAST == '0);
        end else if (arb_en) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_inc;
            val_d = 1'b1;
            if (cnt_inc < cCNT_K) begin
                state_d = DATA;
                dat_d   = sreg_q[0];
                sreg_d  = sreg_q >> 1;
                eop_d   = (cnt_inc == cCNT_KLAST);
            end else begin
                // Zero bits let the encoder shift its check bits out.
                state_d = CHECK;
                dat_d   = 1'b0;
                eof_d   = (cnt_inc == cCNT_LAST);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sreg_q  <= '0;
            rdy_q   <= '0;
            sop_q   <= 1'b0;
            val_q   <= 1'b0;
            eop_q   <= 1'b0;
            eof_q   <= 1'b0;
            tag_q   <= '0;
            dat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (iclkena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sreg_q  <= sreg_d;
            rdy_q   <= rdy_d;
            sop_q   <= sop_d;
            val_q   <= val_d;
            eop_q   <= eop_d;
            eof_q   <= eof_d;
            tag_q   <= tag_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
        end
    end

    assign oreq_rdy = rdy_q;
    assign oenc_sop = sop_q;
    assign oenc_val = val_q;
    assign oenc_eop = eop_q;
    assign oenc_eof = eof_q;
    assign oenc_tag = tag_q;
    assign oenc_dat = dat_q;
    assign obusy    = busy_q;

endmodule

// File: tb/tb_hamming_enc_sched.sv
// Directed bench: two schedulers with pR=3 (K=4), one extended (N=8), one perfect (N=7).
module tb_hamming_enc_sched;

    logic        clk = 1'b0;
    logic        ireset = 1'b0;
    logic        iclkena = 1'b1;

    logic [3:0]  val_a = '0;
    logic [15:0] dat_a = '0;
    logic [3:0]  rdy_a;
    logic        sop_a, v_a, eop_a, eof_a, d_a, busy_a;
    logic [1:0]  tag_a;

    logic [3:0]  val_b = '0;
    logic [15:0] dat_b = '0;
    logic [3:0]  rdy_b;
    logic        sop_b, v_b, eop_b, eof_b, d_b, busy_b;
    logic [1:0]  tag_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp1;
    logic [3:0] bit0s;

    always #5 clk = ~clk;

    hamming_enc_sched #(.pR(3), .pEXT(1), .pN_REQ(4), .pTAG_W(2)) dut_a (
        .iclk     (clk),
        .ireset   (ireset),
        .iclkena  (iclkena),
        .ireq_val (val_a),
        .ireq_dat (dat_a),
        .oreq_rdy (rdy_a),
        .oenc_sop (sop_a),
        .oenc_val (v_a),
        .oenc_eop (eop_a),
        .oenc_eof (eof_a),
        .oenc_tag (tag_a),
        .oenc_dat (d_a),
        .obusy    (busy_a)
    );

    hamming_enc_sched #(.pR(3), .pEXT(0), .pN_REQ(4), .pTAG_W(2)) dut_b (
        .iclk     (clk),
        .ireset   (ireset),
        .iclkena  (iclkena),
        .ireq_val (val_b),
        .ireq_dat (dat_b),
        .oreq_rdy (rdy_b),
        .oenc_sop (sop_b),
        .oenc_val (v_b),
        .oenc_eop (eop_b),
        .oenc_eof (eof_b),
        .oenc_tag (tag_b),
        .oenc_dat (d_b),
        .obusy    (busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_rdy", 32'(rdy_a), 0);
        chk("rst_val", 32'(v_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_sop", 32'(sop_a), 0);
        chk("rst_tag", 32'(tag_a), 0);
        chk("rst_dat", 32'(d_a), 0);
        step();
        ireset = 1'b1;

        // Single word from requester 0
        dat_a[3:0] = 4'b1011;
        exp1 = 8'b0000_1011;
        val_a = 4'b0001;
        step();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) chk("t1_rdy0", 32'(rdy_a), 32'b0001);
            if (c == 1) chk("t1_rdy1", 32'(rdy_a), 0);
            val_a = 4'b0000;
            chk("t1_val", 32'(v_a), 1);
            chk("t1_busy", 32'(busy_a), 1);
            chk("t1_dat", 32'(d_a), 32'(exp1[c]));
            chk("t1_sop", 32'(sop_a), 32'(c == 0));
            chk("t1_eop", 32'(eop_a), 32'(c == 3));
            chk("t1_eof", 32'(eof_a), 32'(c == 7));
            chk("t1_tag", 32'(tag_a), 0);
            step();
        end
        chk("t1_idle_val", 32'(v_a), 0);
        chk("t1_idle_busy", 32'(busy_a), 0);
        chk("t1_idle_eof", 32'(eof_a), 0);

        // All four requesters continuously valid, pointer back at 0
        ireset = 1'b0;
        step();
        ireset = 1'b1;
        dat_a = {4'b0001, 4'b1101, 4'b0110, 4'b1011};
        bit0s = 4'b1101;
        val_a = 4'b1111;
        step();
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 8; c++) begin
                chk("t2_val", 32'(v_a), 1);
                chk("t2_busy", 32'(busy_a), 1);
                chk("t2_sop", 32'(sop_a), 32'(c == 0));
                chk("t2_eof", 32'(eof_a), 32'(c == 7));
                if (c == 0) begin
                    chk("t2_tag", 32'(tag_a), 32'(f % 4));
                    chk("t2_rdy", 32'(rdy_a), 32'(1 << (f % 4)));
                    chk("t2_dat0", 32'(d_a), 32'(bit0s[f%4]));
                    if (f == 4) val_a = 4'b0000;
                end
                step();
            end
        end
        chk("t2_end_val", 32'(v_a), 0);

        // Serve requester 1 so the pointer sits at 2, then only 0 and 3 request
        val_a = 4'b0010;
        step();
        chk("t4_rdy1", 32'(rdy_a), 32'b0010);
        val_a = 4'b0000;
        repeat (8) step();
        chk("t4_idle", 32'(v_a), 0);
        val_a = 4'b1001;
        step();
        chk("t4_rdy3", 32'(rdy_a), 32'b1000);
        chk("t4_tag3", 32'(tag_a), 3);
        val_a = 4'b0001;
        repeat (8) step();
        chk("t4_rdy0", 32'(rdy_a), 32'b0001);
        chk("t4_tag0", 32'(tag_a), 0);
        chk("t4_sop", 32'(sop_a), 1);
        val_a = 4'b0000;
        repeat (8) step();
        chk("t4_end_val", 32'(v_a), 0);

        // Clock-enable stalls at c0 and c2
        dat_a[3:0] = 4'b0101;
        val_a = 4'b0001;
        step();
        chk("t5_rdy", 32'(rdy_a), 32'b0001);
        iclkena = 1'b0;
        val_a = 4'b0000;
        step();
        chk("t5_rdy_hold", 32'(rdy_a), 32'b0001);
        chk("t5_sop_hold", 32'(sop_a), 1);
        iclkena = 1'b1;
        step();
        chk("t5_c1_rdy", 32'(rdy_a), 0);
        chk("t5_c1_dat", 32'(d_a), 0);
        step();
        chk("t5_c2_dat", 32'(d_a), 1);
        iclkena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_frz_dat", 32'(d_a), 1);
            chk("t5_frz_val", 32'(v_a), 1);
            chk("t5_frz_eop", 32'(eop_a), 0);
        end
        iclkena = 1'b1;
        step();
        chk("t5_c3_eop", 32'(eop_a), 1);
        chk("t5_c3_dat", 32'(d_a), 0);
        repeat (3) step();
        chk("t5_c6_eof", 32'(eof_a), 0);
        step();
        chk("t5_c7_eof", 32'(eof_a), 1);
        step();
        chk("t5_end_val", 32'(v_a), 0);

        // Reset mid-frame at c4
        val_a = 4'b0100;
        step();
        chk("t6_rdy2", 32'(rdy_a), 32'b0100);
        chk("t6_tag2", 32'(tag_a), 2);
        val_a = 4'b0000;
        repeat (4) step();
        ireset = 1'b0;
        #1;
        chk("t6_rst_val", 32'(v_a), 0);
        chk("t6_rst_busy", 32'(busy_a), 0);
        chk("t6_rst_tag", 32'(tag_a), 0);
        chk("t6_rst_eof", 32'(eof_a), 0);
        dat_a[7:4] = 4'b0011;
        val_a = 4'b1010;
        step();
        ireset = 1'b1;
        step();
        chk("t6_rdy1", 32'(rdy_a), 32'b0010);
        chk("t6_tag1", 32'(tag_a), 1);
        chk("t6_sop", 32'(sop_a), 1);
        chk("t6_dat0", 32'(d_a), 1);
        val_a = 4'b0000;
        repeat (7) step();
        chk("t6_eof", 32'(eof_a), 1);
        step();
        chk("t6_end_val", 32'(v_a), 0);

        // Perfect code: 7-cycle frames back to back
        dat_b = {8'h00, 4'b0111, 4'b0001};
        val_b = 4'b0011;
        step();
        chk("t3_rdy0", 32'(rdy_b), 32'b0001);
        chk("t3_tag0", 32'(tag_b), 0);
        chk("t3_sop0", 32'(sop_b), 1);
        val_b = 4'b0010;
        for (int c = 1; c < 7; c++) begin
            step();
            chk("t3_val", 32'(v_b), 1);
            chk("t3_eop", 32'(eop_b), 32'(c == 3));
            chk("t3_eof", 32'(eof_b), 32'(c == 6));
        end
        step();
        chk("t3_b2b_sop", 32'(sop_b), 1);
        chk("t3_b2b_val", 32'(v_b), 1);
        chk("t3_b2b_tag", 32'(tag_b), 1);
        chk("t3_b2b_rdy", 32'(rdy_b), 32'b0010);
        val_b = 4'b0000;
        repeat (6) step();
        chk("t3_eof2", 32'(eof_b), 1);
        step();
        chk("t3_end_val", 32'(v_b), 0);
        chk("t3_end_busy", 32'(busy_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_enc_sched.md
Name: hamming_enc_sched

Overview:
- Round-robin scheduler that shares one serial hamming_enc instance between pN_REQ requesters.
- Each requester offers a parallel K-bit payload word with valid/ready handshake.
- The scheduler grants one requester, serializes its word LSB-first, and generates the encoder's isop/ival/ieop/ieof/itag framing, including the check-bit cycles.
- Sits directly in front of hamming_enc; itag carries the requester index so downstream logic can route encoded frames.

Parameters:
- pR, 6, number of hamming check bits; K = 2^pR-1-pR payload bits, localparam cK.
- pEXT, 1, 1 = extended code: frame length cN = 2^pR; 0 = perfect code: cN = 2^pR-1.
- pN_REQ, 4, number of requesters, range 2..16.
- pTAG_W, 2, tag width; must be >= $clog2(pN_REQ).

Ports:
- iclk  in  1  clock.
- ireset  in  1  asynchronous, active-low reset.
- iclkena  in  1  clock enable; when 0, all state and outputs hold.
- ireq_val  in  pN_REQ  per-requester word valid.
- ireq_dat  in  pN_REQ*cK  per-requester payload words; requester i occupies bits [i*cK +: cK].
- oreq_rdy  out  pN_REQ  one-hot accept pulse; handshake completes when ireq_val[i] & oreq_rdy[i].
- oenc_sop  out  1  to encoder isop.
- oenc_val  out  1  to encoder ival.
- oenc_eop  out  1  to encoder ieop (last payload bit).
- oenc_eof  out  1  to encoder ieof (last frame cycle).
- oenc_tag  out  pTAG_W  to encoder itag; granted requester index, zero-extended.
- oenc_dat  out  1  to encoder idat.
- obusy  out  1  high while a frame is in progress.

Behaviour:
- Reset (ireset=0, async):
  - State returns to IDLE; RR pointer = 0; bit counter = 0.
  - All outputs 0, including oreq_rdy, oenc_*, and obusy.
  - Reset mid-frame abandons the frame; no ieof is issued. The encoder must be reset together with this block.
- States:
  - IDLE: no frame active.
  - DATA: cK cycles, payload bits.
  - CHECK: cN-cK cycles; oenc_dat = 0 and oenc_val = 1 so the encoder shifts out rbits.
- Arbitration:
  - Evaluated in IDLE, or in the final CHECK cycle for back-to-back frames.
  - Winner = first i with ireq_val[i] set, searching upward from ptr with wrap-around modulo pN_REQ.
  - On a grant, oreq_rdy[winner] pulses for exactly one cycle (registered, aligned with the grant decision). The word and index are captured into a shift register and tag register.
  - ptr <= winner+1, wrapping to 0 after pN_REQ-1.
  - No grant when no ireq_val bit is set; ptr is unchanged.
- Frame timing (registered outputs):
  - Frame starts the cycle after the grant.
  - Frame cycle c = 0..cN-1 has oenc_val = 1.
  - c = 0: oenc_sop = 1.
  - c < cK: oenc_dat = word[c].
  - c = cK-1: oenc_eop = 1.
  - c = cN-1: oenc_eof = 1.
  - oenc_tag is constant for the whole frame.
- Back-to-back frames: when a grant occurs in cycle cN-1, the next frame's c = 0 immediately follows the eof cycle with no idle cycle. Sustained throughput is one frame per cN cycles.
- Idle between frames: oenc_val = 0; sop/eop/eof = 0; dat and tag hold.
- obusy = 1 from c = 0 through c = cN-1, and stays 1 across back-to-back frames.
- Counter: width $clog2(cN+1). Reset to 0 at each frame start; saturation is unreachable.
- ireq_val deasserted before the grant simply withdraws the request. ireq_dat is sampled only in the accept cycle.
- iclkena = 0 mid-frame: everything freezes, including oreq_rdy (it remains set until the next enabled edge). The encoder shares iclkena.

Decomposition:
- Package hamming_sched_pkg holds:
  - cK and cN computation functions of pR/pEXT.
  - State enum state_t {IDLE, DATA, CHECK}.
- One natural sub-module: hamming_rr_arb, a parameterized round-robin arbiter (pN_REQ; req, ptr in; one-hot grant and index out, combinational).

Test Plan:
- pR=3, pEXT=1 (K=4, N=8). Requester 0 word 4'b1011, others idle.
  - oreq_rdy = 0001 for one cycle.
  - Next 8 cycles: val = 1; dat = 1,1,0,1,0,0,0,0; sop at c0, eop at c3, eof at c7; tag = 0.
  - Encoder odat equals the golden codeword.
- All four requesters valid continuously.
  - Grants in order 0,1,2,3,0; frames back-to-back with no val gap.
  - sop every 8 cycles; tags 0,1,2,3,0.
- pEXT=0.
  - Frame length 7: eof at c6.
  - No idle cycle between back-to-back frames.
- ptr = 2 after serving requester 1; only requesters 0 and 3 valid.
  - Next grant is 3, then 0.
- iclkena held 0 for 5 cycles at c = 2.
  - Outputs frozen.
  - Frame resumes at c = 2; total enabled frame cycles = 8.
- ireset asserted at c = 4 of a frame.
  - All outputs 0 asynchronously; state IDLE; ptr = 0.
  - After release, requester 1 is granted a fresh frame starting at c = 0.
